uart_cmd_ctrl: RTL and testbench

Command controller for the UART link. It parses fixed-length command frames from the UART RX byte stream and executes them against a bank of 8-bit configuration registers that drive camera and lens-filter mode settings. It returns a 3-byte response for each frame through the UART TX FIFO push interface. It sits between the UART block and the video-path configuration inputs.

---
 rtl/uart_cmd_ctrl_pkg.sv | 32 +++
 rtl/uart_cmd_ctrl_if.sv | 27 ++
 rtl/uart_cmd_ctrl_cfg_regfile.sv | 54 +++++
 rtl/uart_cmd_ctrl.sv | 174 +++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared types and byte constants for the UART command controller:
// parser state encoding, frame/response markers and error codes.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CHK,
    ST_EXEC,
    ST_RESP
  } state_e;

  localparam logic [7:0] SOF      = 8'hA5;
  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  localparam logic [7:0] ERR_NONE = 8'h00;
  localparam logic [7:0] ERR_CHK  = 8'h01;
  localparam logic [7:0] ERR_CMD  = 8'h02;
  localparam logic [7:0] ERR_ADDR = 8'h03;

  function automatic logic [7:0] calc_chk(input logic [7:0] cmd,
                                          input logic [7:0] addr,
                                          input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream handshake between the UART block and the command controller:
// RX byte strobe in, TX FIFO push out with FIFO-full backpressure.
interface uart_cmd_if;

  logic       i_rx_valid;
  logic [7:0] i_rx_data;
  logic       i_tx_full;
  logic       o_tx_push;
  logic [7:0] o_tx_data;

  modport slave (
    input  i_rx_valid,
    input  i_rx_data,
    input  i_tx_full,
    output o_tx_push,
    output o_tx_data
  );

  modport master (
    output i_rx_valid,
    output i_rx_data,
    output i_tx_full,
    input  o_tx_push,
    input  o_tx_data
  );

endinterface

// File: rtl/uart_cmd_ctrl_cfg_regfile.sv
// Bank of 8-bit configuration registers with one write port, one read port
// and a flattened view of every register for the video path.
module cfg_regfile #(
  parameter int NUM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [7:0]            rd_addr,
  output logic [7:0]            rd_data,
  output logic [NUM_REGS*8-1:0] cfg
);

  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
      if (wr_en && (int'(wr_addr) == k)) begin
        regs_d[k] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  // Out-of-range read addresses return zero; the caller rejects them anyway.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (int'(rd_addr) == k) begin
        rd_data = regs_q[k];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg[g*8 +: 8] = regs_q[g];
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses SOF/CMD/ADDR/DATA/CHK frames, executes
// register reads/writes and returns a 3-byte response through the TX FIFO.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int NUM_REGS       = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_cmd_if.slave             uart,
  output logic [NUM_REGS*8-1:0] o_cfg,
  output logic                  o_cfg_update,
  output logic                  o_busy,
  output logic                  o_frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] rsp0_q, rsp0_d;
  logic [7:0] rsp1_q, rsp1_d;
  logic [7:0] rsp2_q, rsp2_d;
  logic [1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic       parsing;
  logic       tmo_fire;
  logic [7:0] err_code;
  logic       exec_err;
  logic       wr_en;
  logic [7:0] rd_data;

  cfg_regfile #(
    .NUM_REGS(NUM_REGS)
  ) u_regs (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(addr_q),
    .wr_data(data_q),
    .rd_addr(addr_q),
    .rd_data(rd_data),
    .cfg    (o_cfg)
  );

  // Timeout wins over a byte arriving in the same cycle, so that byte is lost.
  always_comb begin
    parsing  = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
               (state_q == ST_DATA) || (state_q == ST_CHK);
    tmo_fire = parsing && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    if (chk_q != calc_chk(cmd_q, addr_q, data_q)) begin
      err_code = ERR_CHK;
    end else if ((cmd_q != CMD_WR) && (cmd_q != CMD_RD)) begin
      err_code = ERR_CMD;
    end else if (int'(addr_q) >= NUM_REGS) begin
      err_code = ERR_ADDR;
    end else begin
      err_code = ERR_NONE;
    end
    exec_err = (err_code != ERR_NONE);
    wr_en    = (state_q == ST_EXEC) && !exec_err && (cmd_q == CMD_WR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (uart.i_rx_valid && (uart.i_rx_data == SOF)) state_d = ST_CMD;
      ST_CMD:  if (tmo_fire) state_d = ST_IDLE; else if (uart.i_rx_valid) state_d = ST_ADDR;
      ST_ADDR: if (tmo_fire) state_d = ST_IDLE; else if (uart.i_rx_valid) state_d = ST_DATA;
      ST_DATA: if (tmo_fire) state_d = ST_IDLE; else if (uart.i_rx_valid) state_d = ST_CHK;
      ST_CHK:  if (tmo_fire) state_d = ST_IDLE; else if (uart.i_rx_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (!uart.i_tx_full && (idx_q == 2'd2)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_d  = cmd_q;
    addr_d = addr_q;
    data_d = data_q;
    chk_d  = chk_q;
    rsp0_d = rsp0_q;
    rsp1_d = rsp1_q;
    rsp2_d = rsp2_q;
    idx_d  = idx_q;
    tmo_d  = '0;
    if (parsing && !tmo_fire) begin
      if (uart.i_rx_valid) begin
        unique case (state_q)
          ST_CMD:  cmd_d  = uart.i_rx_data;
          ST_ADDR: addr_d = uart.i_rx_data;
          ST_DATA: data_d = uart.i_rx_data;
          ST_CHK:  chk_d  = uart.i_rx_data;
          default: ;
        endcase
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
    // Read data is captured here, before a write in this cycle could land.
    if (state_q == ST_EXEC) begin
      idx_d = 2'd0;
      if (exec_err) begin
        rsp0_d = RSP_ERR;
        rsp1_d = err_code;
        rsp2_d = 8'h00;
      end else begin
        rsp0_d = RSP_OK;
        rsp1_d = addr_q;
        rsp2_d = (cmd_q == CMD_WR) ? data_q : rd_data;
      end
    end
    if ((state_q == ST_RESP) && !uart.i_tx_full) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      chk_q  <= '0;
      rsp0_q <= '0;
      rsp1_q <= '0;
      rsp2_q <= '0;
      idx_q  <= '0;
      tmo_q  <= '0;
    end else begin
      cmd_q  <= cmd_d;
      addr_q <= addr_d;
      data_q <= data_d;
      chk_q  <= chk_d;
      rsp0_q <= rsp0_d;
      rsp1_q <= rsp1_d;
      rsp2_q <= rsp2_d;
      idx_q  <= idx_d;
      tmo_q  <= tmo_d;
    end
  end

  always_comb begin
    uart.o_tx_push = (state_q == ST_RESP) && !uart.i_tx_full;
    uart.o_tx_data = 8'h00;
    if (state_q == ST_RESP) begin
      unique case (idx_q)
        2'd0:    uart.o_tx_data = rsp0_q;
        2'd1:    uart.o_tx_data = rsp1_q;
        default: uart.o_tx_data = rsp2_q;
      endcase
    end
    o_busy       = (state_q != ST_IDLE);
    o_cfg_update = wr_en;
    o_frame_err  = tmo_fire || ((state_q == ST_EXEC) && exec_err);
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: fixed frame table, timeout/resync,
// backpressure and reset-abort sequences, then randomized frames vs a model.
module tb_uart_cmd_ctrl;

  localparam int NUM_REGS = 8;
  localparam int TIMEOUT  = 100;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_REGS*8-1:0] cfg;
  logic cfg_update;
  logic busy;
  logic frame_err;

  always #5 clk = ~clk;

  uart_cmd_if bus ();

  uart_cmd_ctrl #(
    .NUM_REGS      (NUM_REGS),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .uart        (bus),
    .o_cfg       (cfg),
    .o_cfg_update(cfg_update),
    .o_busy      (busy),
    .o_frame_err (frame_err)
  );

  typedef struct {
    logic [39:0] frm;
    logic [23:0] rsp;
    int          upd;
    int          err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [7:0] txq[$];
  int         push_cyc[$];
  int         cyc     = 0;
  int         upd_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] mregs [NUM_REGS];

  // Passive monitor of everything the DUT emits, sampled mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_tx_push) begin
      txq.push_back(bus.o_tx_data);
      push_cyc.push_back(cyc + 1);
    end
    if (cfg_update) upd_cnt <= upd_cnt + 1;
    if (frame_err)  err_cnt <= err_cnt + 1;
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    @(posedge clk);
    #1;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
  endtask

  task automatic applyStimulus(input logic [39:0] frm, input int max_gap);
    for (int i = 0; i < 5; i++) begin
      if (i > 0 && max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          @(posedge clk);
          #1;
        end
      end
      sendByte(frm[39-8*i -: 8]);
    end
  endtask

  task automatic waitIdle(input bit bp_en, output int fall_cyc);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      if (bp_en) bus.i_tx_full = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      #1;
      n++;
    end while (busy && n < 400);
    bus.i_tx_full = 1'b0;
    fall_cyc = cyc;
    checkOutput("wait_idle_busy", 64'(busy), 64'd0);
  endtask

  function automatic logic [NUM_REGS*8-1:0] model_cfg();
    logic [NUM_REGS*8-1:0] v;
    for (int k = 0; k < NUM_REGS; k++) v[k*8 +: 8] = mregs[k];
    return v;
  endfunction

  task automatic modelFrame(input logic [39:0] frm, output logic [23:0] rsp,
                            output int upd, output int err);
    logic [7:0] c, a, d, k;
    c = frm[31:24]; a = frm[23:16]; d = frm[15:8]; k = frm[7:0];
    upd = 0;
    err = 1;
    if (k != (c ^ a ^ d))                rsp = {8'h45, 8'h01, 8'h00};
    else if (c != 8'h57 && c != 8'h52)   rsp = {8'h45, 8'h02, 8'h00};
    else if (int'(a) >= NUM_REGS)        rsp = {8'h45, 8'h03, 8'h00};
    else begin
      err = 0;
      if (c == 8'h57) begin
        rsp = {8'h4B, a, d};
        mregs[a] = d;
        upd = 1;
      end else begin
        rsp = {8'h4B, a, mregs[a]};
      end
    end
  endtask

  task automatic checkFrame(input string tag, input int base, input int upd_base, input int err_base,
                            input logic [23:0] rsp, input int upd, input int err,
                            input bit timing, input int fall_cyc);
    checkOutput({tag, "_push_count"}, 64'(txq.size() - base), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < txq.size())
        checkOutput({tag, "_tx_byte"}, 64'(txq[base+i]), 64'(rsp[23-8*i -: 8]));
    end
    checkOutput({tag, "_cfg_update"}, 64'(upd_cnt - upd_base), 64'(upd));
    checkOutput({tag, "_frame_err"}, 64'(err_cnt - err_base), 64'(err));
    checkOutput({tag, "_cfg"}, 64'(cfg), 64'(model_cfg()));
    if (timing && txq.size() >= base + 3) begin
      checkOutput({tag, "_consecutive"}, 64'(push_cyc[base+2] - push_cyc[base]), 64'd2);
      checkOutput({tag, "_busy_fall"}, 64'(fall_cyc - push_cyc[base+2]), 64'd1);
    end
  endtask

  initial begin
    vec_t vecs[7];
    int base, ub, eb, fall, n, upd, err;
    bit found;
    logic [23:0] rsp;
    logic [39:0] frm;
    logic [7:0] c, a, d, g;

    vecs[0] = '{frm: 40'hA5_57_02_3C_69, rsp: 24'h4B_02_3C, upd: 1, err: 0};
    vecs[1] = '{frm: 40'hA5_52_02_00_50, rsp: 24'h4B_02_3C, upd: 0, err: 0};
    vecs[2] = '{frm: 40'hA5_57_02_3C_00, rsp: 24'h45_01_00, upd: 0, err: 1};
    vecs[3] = '{frm: 40'hA5_57_09_11_4F, rsp: 24'h45_03_00, upd: 0, err: 1};
    vecs[4] = '{frm: 40'hA5_41_00_00_41, rsp: 24'h45_02_00, upd: 0, err: 1};
    vecs[5] = '{frm: 40'hA5_52_08_00_5A, rsp: 24'h45_03_00, upd: 0, err: 1};
    vecs[6] = '{frm: 40'hA5_52_07_00_55, rsp: 24'h4B_07_00, upd: 0, err: 0};

    for (int k = 0; k < NUM_REGS; k++) mregs[k] = '0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
    bus.i_tx_full  = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cfg", 64'(cfg), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_push", 64'(bus.o_tx_push), 64'd0);
    checkOutput("reset_tx_data", 64'(bus.o_tx_data), 64'd0);
    checkOutput("reset_err", 64'(frame_err), 64'd0);
    checkOutput("reset_update", 64'(cfg_update), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] frame table");
    for (int i = 0; i < 7; i++) begin
      base = txq.size(); ub = upd_cnt; eb = err_cnt;
      applyStimulus(vecs[i].frm, 0);
      waitIdle(1'b0, fall);
      if (vecs[i].upd != 0) mregs[vecs[i].frm[23:16]] = vecs[i].frm[15:8];
      checkFrame($sformatf("vec%0d", i), base, ub, eb, vecs[i].rsp, vecs[i].upd, vecs[i].err, 1'b1, fall);
    end
    checkOutput("reg2_value", 64'(cfg[23:16]), 64'h3C);

    $display("[TB] timeout and resync");
    base = txq.size(); eb = err_cnt;
    sendByte(8'hA5);
    sendByte(8'h57);
    n = 0; found = 1'b0;
    while (!found && n < TIMEOUT + 50) begin
      @(negedge clk);
      #1;
      n++;
      if (frame_err) found = 1'b1;
    end
    checkOutput("timeout_latency", 64'(n), 64'(TIMEOUT));
    repeat (3) @(negedge clk);
    #1;
    checkOutput("timeout_err_count", 64'(err_cnt - eb), 64'd1);
    checkOutput("timeout_no_push", 64'(txq.size() - base), 64'd0);
    checkOutput("timeout_idle", 64'(busy), 64'd0);
    base = txq.size(); ub = upd_cnt; eb = err_cnt;
    sendByte(8'h13);
    applyStimulus(40'hA5_57_01_FF_A9, 0);
    waitIdle(1'b0, fall);
    mregs[1] = 8'hFF;
    checkFrame("resync", base, ub, eb, 24'h4B_01_FF, 1, 0, 1'b1, fall);

    $display("[TB] backpressure");
    base = txq.size(); ub = upd_cnt; eb = err_cnt;
    bus.i_tx_full = 1'b1;
    applyStimulus(40'hA5_57_05_5A_08, 0);
    repeat (20) @(negedge clk);
    #1;
    checkOutput("bp_no_push", 64'(txq.size() - base), 64'd0);
    checkOutput("bp_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    bus.i_tx_full = 1'b0;
    waitIdle(1'b0, fall);
    mregs[5] = 8'h5A;
    checkFrame("bp", base, ub, eb, 24'h4B_05_5A, 1, 0, 1'b1, fall);

    $display("[TB] reset during response");
    base = txq.size();
    applyStimulus(40'hA5_57_03_77_23, 0);
    n = 0;
    while (txq.size() == base && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rst_push", 64'(bus.o_tx_push), 64'd0);
    checkOutput("rst_cfg", 64'(cfg), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pushed_once", 64'(txq.size() - base), 64'd1);
    reset = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) mregs[k] = '0;
    @(posedge clk);
    #1;
    base = txq.size(); ub = upd_cnt; eb = err_cnt;
    applyStimulus(40'hA5_57_04_C3_90, 0);
    waitIdle(1'b0, fall);
    mregs[4] = 8'hC3;
    checkFrame("post_rst", base, ub, eb, 24'h4B_04_C3, 1, 0, 1'b1, fall);

    $display("[TB] randomized frames");
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 4);
      c = (n < 2) ? 8'h57 : (n < 4) ? 8'h52 : 8'($urandom_range(0, 255));
      a = 8'($urandom_range(0, 11));
      d = 8'($urandom_range(0, 255));
      frm = {8'hA5, c, a, d, ($urandom_range(0, 3) != 0) ? (c ^ a ^ d) : 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        sendByte(g);
      end
      base = txq.size(); ub = upd_cnt; eb = err_cnt;
      modelFrame(frm, rsp, upd, err);
      applyStimulus(frm, 3);
      waitIdle(1'b1, fall);
      checkFrame($sformatf("rand%0d", i), base, ub, eb, rsp, upd, err, 1'b0, fall);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
